// File: rtl/serial_addsub_multi_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
// Holds the control FSM state encoding and the helpers that derive the
// digit count and digit-counter width from the word and digit widths.
package serial_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Digits per word
    function automatic int ndig(input int word_w, input int digit_w);
        return word_w / digit_w;
    endfunction

    // Digit-counter width; a one-digit word still gets a 1-bit counter
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter sizing for the default 8-bit word, 2-bit digit build
    localparam int NDIG_DEF  = ndig(8, 2);
    localparam int IDX_W_DEF = idx_width(NDIG_DEF);

endpackage

// File: rtl/serial_addsub_multi_if.sv
// Digit stream bundle between serialiser, add/sub unit and accumulator.
// master drives digits in and receives result digits; slave is the unit.
// in_*/sub/x/y travel in; out_*/sum/carry_out/ovf/err travel out.
interface serial_addsub_multi_if #(
    parameter int CHANNELS = 2,
    parameter int DIGIT_W  = 2
);
    logic                        in_valid;
    logic                        in_first;
    logic                        sub;
    logic [CHANNELS*DIGIT_W-1:0] x;
    logic [CHANNELS*DIGIT_W-1:0] y;
    logic                        out_valid;
    logic [CHANNELS*DIGIT_W-1:0] sum;
    logic                        out_last;
    logic [CHANNELS-1:0]         carry_out;
    logic [CHANNELS-1:0]         ovf;
    logic                        err;

    modport master (
        output in_valid, in_first, sub, x, y,
        input  out_valid, sum, out_last, carry_out, ovf, err
    );

    modport slave (
        input  in_valid, in_first, sub, x, y,
        output out_valid, sum, out_last, carry_out, ovf, err
    );
endinterface

// File: rtl/serial_addsub_multi_adder.sv
// One lane, one digit: combinational add of a and (b optionally inverted) plus cin.
// Ports: a, b, cin, inv in; s, cout out; cmsb_in (carry into MSB) only when
// SERIAL_ADDSUB_OVF_EN is defined. Zero latency, no flow control.
module serial_digit_adder #(
    parameter int DIGIT_W = 2
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               inv,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic               cmsb_in
`endif
);
    logic [DIGIT_W-1:0] b_eff;

    assign b_eff       = b ^ {DIGIT_W{inv}};
    assign {cout, s}   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};

`ifdef SERIAL_ADDSUB_OVF_EN
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of it
    assign cmsb_in = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
`endif
endmodule

// File: rtl/serial_addsub_multi.sv
// Digit-serial multi-lane add/subtract, LSB first; ports clk, rst, clr, bus (slave).
// Latency 1 cycle in_valid -> out_valid; SERIAL_ADDSUB_OVF_EN enables ovf, else ovf=0.
// No backpressure: in_valid=0 stalls and holds carry/idx/sub/state; orphans drop with err.
module serial_addsub_multi
    import serial_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIGIT_W  = 2,
    parameter int WORD_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    serial_addsub_multi_if.slave  bus
);
    localparam int NDIG = ndig(WORD_W, DIGIT_W);
    localparam int IW   = idx_width(NDIG);

    if (WORD_W % DIGIT_W != 0) begin : g_bad_word_w
        $error("WORD_W must be a multiple of DIGIT_W");
    end

    state_e                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d, eff_idx;
    logic                        sub_q, sub_d, sub_eff;
    logic [CHANNELS-1:0]         carry_q, carry_d, cin_vec, cout_vec;
    logic [CHANNELS*DIGIT_W-1:0] sum_q, sum_d, s_vec;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic [CHANNELS-1:0]         carry_out_q, carry_out_d;
    logic                        err_q, err_d;
    logic                        start, cont, orphan, accept, last;

    // A first digit is accepted in either state, which is how a word is aborted
    assign start   = bus.in_valid & bus.in_first;
    assign cont    = bus.in_valid & ~bus.in_first & (state_q == S_BUSY);
    assign orphan  = bus.in_valid & ~bus.in_first & (state_q == S_IDLE);
    assign accept  = start | cont;
    assign sub_eff = start ? bus.sub : sub_q;
    assign eff_idx = start ? '0 : idx_q;
    assign last    = (eff_idx == IW'(NDIG - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
    logic [CHANNELS-1:0] cmsb_vec;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        // Subtract is x + ~y + 1: the +1 enters as carry-in of digit 0
        assign cin_vec[c] = start ? bus.sub : carry_q[c];
        serial_digit_adder #(.DIGIT_W(DIGIT_W)) u_add (
            .a       (bus.x[c*DIGIT_W +: DIGIT_W]),
            .b       (bus.y[c*DIGIT_W +: DIGIT_W]),
            .cin     (cin_vec[c]),
            .inv     (sub_eff),
            .s       (s_vec[c*DIGIT_W +: DIGIT_W]),
            .cout    (cout_vec[c])
`ifdef SERIAL_ADDSUB_OVF_EN
            ,
            .cmsb_in (cmsb_vec[c])
`endif
        );
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        out_valid_d = accept;
        out_last_d  = accept & last;
        err_d       = orphan;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (accept) begin
            sub_d   = sub_eff;
            carry_d = cout_vec;
            sum_d   = s_vec;
            idx_d   = last ? '0 : eff_idx + IW'(1);
            state_d = last ? S_IDLE : S_BUSY;
            if (last) begin
                carry_out_d = cout_vec;
`ifdef SERIAL_ADDSUB_OVF_EN
                ovf_d       = cmsb_vec ^ cout_vec;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out_q <= '0;
            err_q       <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            carry_out_q <= carry_out_d;
            err_q       <= err_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.carry_out = carry_out_q;
    assign bus.err       = err_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = '0;
`endif
endmodule
